// File: rtl/adder32_rr_arbiter_pkg.sv
// Shared constants and helpers for the round-robin arbiter that fronts one 32-bit adder.
package adder32_rr_arbiter_pkg;

    localparam int ADD_WIDTH = 32;
    localparam int MAX_REQ   = 8;
    localparam int PTR_W     = 3;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Returns the one-hot winner: the first set bit of valid at or after ptr, wrapping at nreq.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input logic [PTR_W-1:0]   ptr,
                                                   input int                 nreq);
        logic [MAX_REQ-1:0] onehot;
        logic [PTR_W-1:0]   sel;
        onehot = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            sel = PTR_W'((int'(ptr) + k) % nreq);
            if (k < nreq && onehot == '0 && valid[sel]) begin
                onehot[sel] = 1'b1;
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/adder32_rr_arbiter_rr_arbiter_core.sv
// Round-robin pointer plus rotate/priority pick; the pointer moves past the winner only on a transfer.
module rr_arbiter_core
    import adder32_rr_arbiter_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    input  logic            enable,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_any
);

    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [MAX_REQ-1:0] pick;

    // NOTE: every output of this block gets a default before any branch, so no latch can be inferred.
    always_comb begin
        pick    = rr_pick(MAX_REQ'(req_valid), PTR_W'(ptr_q), NREQ);
        gnt     = enable ? pick[NREQ-1:0] : '0;
        gnt_any = |gnt;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                gnt_idx = IDW'(i);
            end
        end
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : IDW'(int'(gnt_idx) + 1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/thirtytwo_bit_Recursive_Carry_Adder.sv
// 32-bit Kogge-Stone adder: five prefix levels of generate/propagate, no carry-in.
module thirtytwo_bit_Recursive_Carry_Adder (
    output logic [31:0] sum,
    output logic        cout,
    input  logic [31:0] a,
    input  logic [31:0] b
);

    logic [31:0] g_lvl, p_lvl, g_nxt, p_nxt;

    always_comb begin
        g_lvl = a & b;
        p_lvl = a ^ b;
        g_nxt = '0;
        p_nxt = '0;
        for (int l = 0; l < 5; l++) begin
            g_nxt = g_lvl;
            p_nxt = p_lvl;
            for (int i = (1 << l); i < 32; i++) begin
                g_nxt[i] = g_lvl[i] | (p_lvl[i] & g_lvl[i - (1 << l)]);
                p_nxt[i] = p_lvl[i] & p_lvl[i - (1 << l)];
            end
            g_lvl = g_nxt;
            p_lvl = p_nxt;
        end
        // g_lvl[i] is now the carry out of bit i.
        sum  = (a ^ b) ^ {g_lvl[30:0], 1'b0};
        cout = g_lvl[31];
    end

endmodule

// File: rtl/adder32_rr_arbiter.sv
// Shares one 32-bit adder among NREQ requesters; results return through a one-deep tagged response slot.
module adder32_rr_arbiter
    import adder32_rr_arbiter_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = ADD_WIDTH,
    localparam int IDW   = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout
);

    if (WIDTH != ADD_WIDTH) begin : g_bad_width
        $error("adder32_rr_arbiter: WIDTH must be 32");
    end
    if (NREQ < 2 || NREQ > MAX_REQ) begin : g_bad_nreq
        $error("adder32_rr_arbiter: NREQ must be in 2..8");
    end

    logic             can_issue;
    logic             gnt_any;
    logic [IDW-1:0]   gnt_idx;
    logic [WIDTH-1:0] op_a, op_b, add_sum;
    logic             add_cout;

    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;

    // The slot can take a new result when empty or when it is being drained this same cycle.
    assign can_issue = ~rsp_valid_q | rsp_ready;

    rr_arbiter_core #(.NREQ(NREQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .enable    (can_issue),
        .gnt       (req_ready),
        .gnt_idx   (gnt_idx),
        .gnt_any   (gnt_any)
    );

    assign op_a = req_a[int'(gnt_idx) * WIDTH +: WIDTH];
    assign op_b = req_b[int'(gnt_idx) * WIDTH +: WIDTH];

    thirtytwo_bit_Recursive_Carry_Adder u_add (
        .sum  (add_sum),
        .cout (add_cout),
        .a    (op_a),
        .b    (op_b)
    );

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        if (gnt_any) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gnt_idx;
            rsp_sum_d   = add_sum;
            rsp_cout_d  = add_cout;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // NOTE: the data registers are reset too, so the idle response reads as zero rather than X.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_adder32_rr_arbiter.sv
// Directed scenarios plus constrained-random traffic, checked every cycle against a behavioural model.
module tb_adder32_rr_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;

    int n_cmp = 0;
    int n_bad = 0;

    adder32_rr_arbiter #(.NREQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           m_init = 0;
    bit           m_valid;
    int           m_id, m_ptr;
    logic [31:0]  m_sum;
    bit           m_cout;
    logic [N-1:0] m_acc;
    int           w;
    logic [32:0]  full;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(input logic [N-1:0] v, input int p,
                                               input bit full_slot, input logic drain);
        int g;
        g = pick(v, p);
        if (g < 0 || (full_slot && !drain)) return '0;
        return N'(1) << g;
    endfunction

    always @(posedge clk) begin
        m_acc = '0;
        if (rst) begin
            m_init  = 1;
            m_valid = 0;
            m_id    = 0;
            m_sum   = '0;
            m_cout  = 0;
            m_ptr   = 0;
        end else if (m_init) begin
            w = pick(req_valid, m_ptr);
            if ((!m_valid || rsp_ready) && w >= 0) begin
                full     = {1'b0, req_a[w*W +: W]} + {1'b0, req_b[w*W +: W]};
                m_sum    = full[31:0];
                m_cout   = full[32];
                m_id     = w;
                m_valid  = 1;
                m_ptr    = (w + 1) % N;
                m_acc[w] = 1'b1;
            end else if (m_valid && rsp_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init && !rst) begin
            check("req_ready", 64'(req_ready), 64'(exp_ready(req_valid, m_ptr, m_valid, rsp_ready)));
            check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
            check("rsp_id",    64'(rsp_id),    64'(m_id));
            check("rsp_sum",   64'(rsp_sum),   64'(m_sum));
            check("rsp_cout",  64'(rsp_cout),  64'(m_cout));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // 1. reset then idle
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) step();
        @(negedge clk);
        check("idle_valid", 64'(rsp_valid), 64'd0);
        check("idle_ready", 64'(req_ready), 64'd0);
        check("idle_sum",   64'(rsp_sum),   64'd0);

        // 2. single request with wrap-around
        step();
        rsp_ready = 1'b1;
        set_op(2, 32'hFFFF_FFFF, 32'h0000_0001);
        req_valid = 4'b0100;
        @(negedge clk);
        check("single_ready", 64'(req_ready), 64'b0100);
        step();
        req_valid = '0;
        @(negedge clk);
        check("single_valid", 64'(rsp_valid), 64'd1);
        check("single_id",    64'(rsp_id),    64'd2);
        check("single_sum",   64'(rsp_sum),   64'h0);
        check("single_cout",  64'(rsp_cout),  64'd1);

        // 3. full contention from ptr=0
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_op(i, 32'(i), 32'hAAAA_AAAA);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("cont_ready", 64'(req_ready), 64'(4'b0001 << (k % N)));
            if (k > 0) begin
                check("cont_id",  64'(rsp_id),  64'((k - 1) % N));
                check("cont_sum", 64'(rsp_sum), 64'(32'hAAAA_AAAA + 32'((k - 1) % N)));
            end
            step();
        end

        // 4. backpressure with requesters 1 and 3 waiting
        req_valid = 4'b1010;
        rsp_ready = 1'b0;
        set_op(1, 32'h1234_5678, 32'h1111_1111);
        set_op(3, 32'hF000_0000, 32'h2000_0000);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("bp_ready", 64'(req_ready), 64'd0);
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_id",    64'(rsp_id),    64'd0);
            check("bp_sum",   64'(rsp_sum),   64'hAAAA_AAAA);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_grant1", 64'(req_ready), 64'b0010);
        step();
        req_valid = 4'b1000;
        @(negedge clk);
        check("bp_grant3", 64'(req_ready), 64'b1000);
        check("bp_rsp1",   64'(rsp_sum),   64'h2345_6789);
        step();
        req_valid = '0;
        @(negedge clk);
        check("bp_rsp3_id",   64'(rsp_id),   64'd3);
        check("bp_rsp3_sum",  64'(rsp_sum),  64'h1000_0000);
        check("bp_rsp3_cout", 64'(rsp_cout), 64'd1);

        // 5. pointer skip and wrap
        step();
        set_op(2, 32'd5, 32'd6);
        req_valid = 4'b0100;
        @(negedge clk);
        check("skip_g2", 64'(req_ready), 64'b0100);
        step();
        set_op(1, 32'h8000_0001, 32'h8000_0007);
        req_valid = 4'b0010;
        @(negedge clk);
        check("skip_g1", 64'(req_ready), 64'b0010);
        step();
        req_valid = 4'b1101;
        @(negedge clk);
        check("skip_sum",  64'(rsp_sum),   64'h0000_0008);
        check("skip_cout", 64'(rsp_cout),  64'd1);
        check("skip_ptr2", 64'(req_ready), 64'b0100);

        // 6. reset in the same cycle as a grant, with a response pending
        step();
        req_valid = 4'b0001;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_ptr0",  64'(req_ready), 64'b0001);
        step();
        req_valid = '0;

        // 7. random traffic honouring the hold-until-ready contract
        for (int c = 0; c < 3000; c++) begin
            step();
            rst = ($urandom_range(0, 599) == 0);
            rsp_ready = ($urandom_range(0, 99) < 70);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || m_acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 99) < 55);
                    set_op(i, rand_op(), rand_op());
                end
            end
        end
        step();
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adder32_rr_arbiter.md
Name: adder32_rr_arbiter

Overview:
- Shares one 32-bit Kogge-Stone adder (thirtytwo_bit_Recursive_Carry_Adder: sum, cout, a, b; no carry-in) between NREQ independent requesters.
- Round-robin arbitration over a per-requester valid/ready handshake.
- Results leave through a single registered response channel, tagged with the requester ID.
- Sits between client blocks and the adder so that no second adder instance is needed.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- WIDTH, 32, operand width; fixed at 32 to match the adder. Any other value is a configuration error.
- IDW, $clog2(NREQ), width of the requester ID; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  bit i: requester i presents an operand pair.
- req_ready  out  NREQ  bit i: requester i's pair is accepted this cycle; one-hot or zero.
- req_a  in  NREQ*WIDTH  operand a for requester i, at bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand b for requester i, at the same slices.
- rsp_valid  out  1  response slot holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_sum  out  WIDTH  a+b mod 2^32.
- rsp_cout  out  1  carry out of bit 31.

Behaviour:
- Reset (rst=1 at a clk edge):
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0.
  - Round-robin pointer ptr=0.
  - Reset overrides everything, including a grant in the same cycle. A pending response is discarded mid-operation.
- Response slot states:
  - EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - can_issue = ~rsp_valid | rsp_ready.
- Arbitration (combinational):
  - Search req_valid starting at index ptr, then ptr+1, and so on, wrapping modulo NREQ.
  - The first set bit is the winner g.
  - req_ready = onehot(g) when can_issue and any req_valid; otherwise all zero.
  - A requester with valid=0 never receives ready.
- Issue (transfer when req_valid[g] & req_ready[g]):
  - Muxed req_a/req_b slices of g drive the adder.
  - At the clk edge, the registers load rsp_sum, rsp_cout and rsp_id=g, and set rsp_valid=1.
  - Latency is exactly 1 cycle from acceptance to rsp_valid.
  - ptr <= (g+1) mod NREQ. The pointer advances only on a transfer.
- Drain:
  - rsp_valid & rsp_ready with no new issue: rsp_valid <= 0. Data registers hold their stale values.
  - rsp_valid & rsp_ready with a new issue in the same cycle: the slot is overwritten with the new result and rsp_valid stays 1. This gives back-to-back throughput of one add per cycle.
- Backpressure:
  - rsp_valid=1 and rsp_ready=0: all req_ready=0.
  - Response outputs are held stable until accepted.
- Requester contract:
  - A requester holds req_valid, req_a and req_b stable until ready. The block does not check this.
  - The block never drops an accepted request.
- Fairness: with all NREQ requesters continuously valid and rsp_ready=1, grants cycle 0,1,…,NREQ-1,0,… and each requester is served within NREQ transfers.
- Arithmetic:
  - Unsigned, 33-bit result {cout,sum}.
  - Wrap-around: 0xFFFFFFFF+0x00000001 gives sum=0 and cout=1.
- Timing: the adder is purely combinational inside the issue cycle. The path req_valid → ptr compare → mux → adder → register must meet clk.

Decomposition:
- Shared package:
  - WIDTH=32 constant.
  - Function for ID width (clog2).
  - Function rr_pick(valid, ptr) that returns the one-hot winner.
- Sub-modules:
  - One natural sub-module, rr_arbiter_core: ptr register plus rotate/priority-encode, outputs one-hot grant and index.
  - The existing thirtytwo_bit_Recursive_Carry_Adder is instantiated unchanged.
- The top level holds the operand mux and the response register.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then rst=0 with no valids → rsp_valid=0, req_ready=0000, rsp_sum=0 for 10 cycles.
2. Single request:
   - Stimulus: req 2 only, a=0xFFFFFFFF, b=0x00000001, rsp_ready=1.
   - Required: req_ready=0100 in cycle 0; next cycle rsp_valid=1, rsp_id=2, rsp_sum=0x00000000, rsp_cout=1.
3. Full contention:
   - Stimulus: all 4 valid continuously, requester i uses a=i, b=0xAAAAAAAA, rsp_ready=1.
   - Required: grant order 0,1,2,3,0; one response per cycle; rsp_sum=0xAAAAAAAA+i, cout=0.
4. Backpressure:
   - Stimulus: response pending with rsp_ready=0 for 5 cycles while requesters 1 and 3 are valid.
   - Required: req_ready=0000 and rsp_* stable throughout. After rsp_ready=1, requester 1 is granted, then requester 3, and no request is lost.
5. Pointer skip and wrap:
   - Stimulus: ptr=3 after granting 2, then only requester 1 valid with a=0x80000001, b=0x80000007.
   - Required: requester 1 is granted; rsp_sum=0x00000008, cout=1; ptr=2.
6. Reset mid-operation:
   - Stimulus: rst asserted in the same cycle as a grant, with rsp_valid=1 pending.
   - Required: the next cycle has rsp_valid=0 and ptr=0, and the granted request produces no response.
